// File: rtl/pc_redirect_ctrl_if.sv
// Bundle between the fetch next-PC controller and the surrounding pipeline.
// Optional misalign_trap member exists only when PC_REDIRECT_MISALIGN_TRAP_EN is defined.
interface pc_redirect_ctrl_if;
  // Flow control: stall_if=1 means fetch refuses the PC offered this cycle; the
  // controller holds pc_out and parks any redirect until a cycle with stall_if=0.
  logic        stall_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic        flush_if;
  logic        flush_id;
  logic        redirect_pending;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_pending_target;
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
  logic        misalign_trap;

  modport master (
    input  stall_if, id_valid, id_pc, id_instruction, ex_redirect, ex_target,
    output pc_out, fetch_valid, flush_if, flush_id, redirect_pending,
           dbg_state, dbg_pending_target, misalign_trap
  );
  modport slave (
    output stall_if, id_valid, id_pc, id_instruction, ex_redirect, ex_target,
    input  pc_out, fetch_valid, flush_if, flush_id, redirect_pending,
           dbg_state, dbg_pending_target, misalign_trap
  );
`else
  modport master (
    input  stall_if, id_valid, id_pc, id_instruction, ex_redirect, ex_target,
    output pc_out, fetch_valid, flush_if, flush_id, redirect_pending,
           dbg_state, dbg_pending_target
  );
  modport slave (
    output stall_if, id_valid, id_pc, id_instruction, ex_redirect, ex_target,
    input  pc_out, fetch_valid, flush_if, flush_id, redirect_pending,
           dbg_state, dbg_pending_target
  );
`endif
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch next-PC controller: arbitrates EX redirect > ID JAL > pending > PC+4.
// Optional macro PC_REDIRECT_MISALIGN_TRAP_EN sends misaligned targets to TRAP_VECTOR.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  pc_redirect_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_q, pend_d;
  logic        pend_ex_q, pend_ex_d;
  logic        fv_q, fv_d;
  logic        trap_q, trap_d;

  logic        active;
  logic        jal_det;
  logic [31:0] jal_imm;
  logic [31:0] jal_tgt;
  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] jump_tgt;

  assign active  = (state_q != S_BOOT);
  assign jal_det = bus.id_valid && (bus.id_instruction[6:0] == OPC_JAL);
  assign jal_imm = {{11{bus.id_instruction[31]}}, bus.id_instruction[31],
                    bus.id_instruction[19:12], bus.id_instruction[20],
                    bus.id_instruction[30:21], 1'b0};
  assign jal_tgt   = bus.id_pc + jal_imm;
  assign redir     = active && (bus.ex_redirect || jal_det);
  assign redir_tgt = bus.ex_redirect ? bus.ex_target : jal_tgt;
  assign jump_tgt  = redir ? redir_tgt : pend_tgt_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_d     = pend_q;
    pend_ex_d  = pend_ex_q;
    fv_d       = fv_q;
    trap_d     = 1'b0;
    if (state_q == S_BOOT) begin
      fv_d    = 1'b1;
      state_d = S_RUN;
    end else if (!bus.stall_if) begin
      pend_d  = 1'b0;
      state_d = S_RUN;
      if (redir || pend_q) begin
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
        if (jump_tgt[1:0] != 2'b00) begin
          pc_d   = TRAP_VECTOR;
          trap_d = 1'b1;
        end else begin
          pc_d = jump_tgt;
        end
`else
        pc_d = jump_tgt;
`endif
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else if (bus.ex_redirect) begin
      pend_d     = 1'b1;
      pend_ex_d  = 1'b1;
      pend_tgt_d = bus.ex_target;
      state_d    = S_HOLD;
    end else if (jal_det && !(pend_q && pend_ex_q)) begin
      // A parked EX redirect is older and architecturally stronger than any ID JAL.
      pend_d     = 1'b1;
      pend_ex_d  = 1'b0;
      pend_tgt_d = jal_tgt;
      state_d    = S_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      pend_tgt_q <= 32'h0;
      pend_q     <= 1'b0;
      pend_ex_q  <= 1'b0;
      fv_q       <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_q     <= pend_d;
      pend_ex_q  <= pend_ex_d;
      fv_q       <= fv_d;
      trap_q     <= trap_d;
    end
  end

  assign bus.pc_out             = pc_q;
  assign bus.fetch_valid        = fv_q;
  assign bus.redirect_pending   = pend_q;
  assign bus.flush_if           = !rst && redir;
  assign bus.flush_id           = !rst && active && bus.ex_redirect;
  assign bus.dbg_state          = state_q;
  assign bus.dbg_pending_target = pend_tgt_q;

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
  assign bus.misalign_trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = ^{TRAP_VECTOR, trap_q};
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: reset/boot, JAL targets, priority, stall parking.
module tb_pc_redirect_ctrl;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_q[$];

  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected PC values are queued, then consumed one per check.
  task automatic chk_pc(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    chk(tag, bus.pc_out, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_if       = 1'b0;
    bus.id_valid       = 1'b0;
    bus.id_pc          = 32'h0;
    bus.id_instruction = 32'h0000_0013;
    bus.ex_redirect    = 1'b0;
    bus.ex_target      = 32'h0;
  endtask

  task automatic drive_jal(input logic [31:0] pc, input logic [31:0] instr);
    bus.id_valid       = 1'b1;
    bus.id_pc          = pc;
    bus.id_instruction = instr;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h2000;
    repeat (3) step();
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_fv", {31'h0, bus.fetch_valid}, 32'h0);
    chk("rst_pend", {31'h0, bus.redirect_pending}, 32'h0);
    chk("rst_flush_if", {31'h0, bus.flush_if}, 32'h0);
    chk("rst_flush_id", {31'h0, bus.flush_id}, 32'h0);

    // Release into BOOT with a JAL present: it must be ignored.
    idle_inputs();
    rst = 1'b0;
    drive_jal(32'h1000, 32'h0100_006F);
    #1;
    chk("boot_fv", {31'h0, bus.fetch_valid}, 32'h0);
    chk("boot_state", {30'h0, bus.dbg_state}, 32'd0);
    chk("boot_flush_if", {31'h0, bus.flush_if}, 32'h0);
    exp_q.push_back(32'h0);
    step();
    chk("run_fv", {31'h0, bus.fetch_valid}, 32'h1);
    chk_pc("first_fetch");
    idle_inputs();
    exp_q.push_back(32'h4);
    step();
    chk_pc("seq_4");
    exp_q.push_back(32'h8);
    step();
    chk_pc("seq_8");

    // Forward JAL
    drive_jal(32'h1000, 32'h0100_006F);
    #1;
    chk("fjal_flush_if", {31'h0, bus.flush_if}, 32'h1);
    chk("fjal_flush_id", {31'h0, bus.flush_id}, 32'h0);
    exp_q.push_back(32'h1010);
    step();
    chk_pc("fjal_pc");
    idle_inputs();
    exp_q.push_back(32'h1014);
    step();
    chk_pc("fjal_seq");

    // Backward JAL wrapping below zero
    drive_jal(32'h0, 32'hFFDF_F06F);
    exp_q.push_back(32'hFFFF_FFFC);
    step();
    chk_pc("bjal_wrap");
    idle_inputs();
    exp_q.push_back(32'h0);
    step();
    chk_pc("seq_wrap");

    // EX and JAL together: EX wins
    drive_jal(32'h1000, 32'h0100_006F);
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h2000;
    #1;
    chk("sim_flush_if", {31'h0, bus.flush_if}, 32'h1);
    chk("sim_flush_id", {31'h0, bus.flush_id}, 32'h1);
    exp_q.push_back(32'h2000);
    step();
    chk_pc("sim_pc");
    idle_inputs();
    exp_q.push_back(32'h2004);
    step();
    chk_pc("sim_jal_dropped");

    // Stall: JAL parked, then EX overwrites, then JAL cannot overwrite EX
    bus.stall_if = 1'b1;
    drive_jal(32'h1000, 32'h0100_006F);
    #1;
    chk("stall_flush_if", {31'h0, bus.flush_if}, 32'h1);
    step();
    chk("stall_pc_hold", bus.pc_out, 32'h2004);
    chk("stall_pend", {31'h0, bus.redirect_pending}, 32'h1);
    chk("stall_tgt_jal", bus.dbg_pending_target, 32'h1010);
    chk("stall_state", {30'h0, bus.dbg_state}, 32'd2);
    bus.id_valid    = 1'b0;
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h3000;
    #1;
    chk("stall_ex_flush_id", {31'h0, bus.flush_id}, 32'h1);
    step();
    chk("stall_tgt_ex", bus.dbg_pending_target, 32'h3000);
    chk("stall_pc_hold2", bus.pc_out, 32'h2004);
    bus.ex_redirect = 1'b0;
    drive_jal(32'h1000, 32'h0100_006F);
    step();
    chk("stall_tgt_kept", bus.dbg_pending_target, 32'h3000);
    chk("stall_pend2", {31'h0, bus.redirect_pending}, 32'h1);
    idle_inputs();
    exp_q.push_back(32'h3000);
    step();
    chk_pc("release_pc");
    chk("release_pend", {31'h0, bus.redirect_pending}, 32'h0);
    chk("release_state", {30'h0, bus.dbg_state}, 32'd1);
    exp_q.push_back(32'h3004);
    step();
    chk_pc("release_seq");

    // Misaligned EX target
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h2002;
    step();
    idle_inputs();
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    chk("trap_pc", bus.pc_out, 32'h100);
    chk("trap_pulse", {31'h0, bus.misalign_trap}, 32'h1);
    step();
    chk("trap_pulse_end", {31'h0, bus.misalign_trap}, 32'h0);
    chk("trap_seq", bus.pc_out, 32'h104);
`else
    chk("misalign_raw", bus.pc_out, 32'h2002);
    step();
    chk("misalign_seq", bus.pc_out, 32'h2006);
`endif

    // Reset mid-stall discards the parked redirect
    bus.stall_if    = 1'b1;
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 32'h5000;
    step();
    chk("pre_rst_pend", {31'h0, bus.redirect_pending}, 32'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_pend", {31'h0, bus.redirect_pending}, 32'h0);
    chk("mid_rst_pc", bus.pc_out, 32'h0);
    chk("mid_rst_tgt", bus.dbg_pending_target, 32'h0);
    rst = 1'b0;
    idle_inputs();
    step();
    chk("mid_rst_boot_pc", bus.pc_out, 32'h0);
    step();
    chk("mid_rst_seq", bus.pc_out, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
